// File: rtl/adc_burst_avg.sv
// adc_burst_avg: burst-sampling ADC averager.
// A synchronized rising edge on syncro_i starts a burst: after SYNC_DELAY
// cycles the block raises adc_data_req_o, accumulates 2^LOG2_N samples taken
// on falling edges of adc_data_rdy_i, and publishes their signed mean on
// data_o with a one-cycle data_rdy_o pulse. A stalled burst aborts after
// TIMEOUT strobe-less REQ cycles with a timeout_o pulse.
// Optional feature macro: ADC_AVG_ROUND_EN (round half up instead of floor).
module adc_burst_avg #(
    parameter int DATA_W     = 12,
    parameter int LOG2_N     = 3,
    parameter int SYNC_DELAY = 10,
    parameter int TIMEOUT    = 64
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic              syncro_i,
    output logic              adc_data_req_o,
    input  logic              adc_data_rdy_i,
    input  logic [DATA_W-1:0] adc_data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_rdy_o,
    output logic              busy_o,
    output logic              timeout_o
);

    localparam int N     = 1 << LOG2_N;
    localparam int ACC_W = DATA_W + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam int DLY_W = 8;
    localparam int TMO_W = 16;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] REQ   = 2'd2;
    localparam logic [1:0] OUT   = 2'd3;

    logic [1:0]              state, next_state;
    logic [2:0]              sync_q;
    logic                    sync_edge;
    logic                    rdy_z;
    logic                    strobe;
    logic                    start;
    logic                    last_smp;
    logic                    expire;
    logic [DLY_W-1:0]        dly_cnt;
    logic [TMO_W-1:0]        tmo_cnt;
    logic [CNT_W-1:0]        smp_cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_rnd;
    logic signed [ACC_W-1:0] sample_ext;

    assign sync_edge  = sync_q[1] & ~sync_q[2];
    assign strobe     = rdy_z & ~adc_data_rdy_i;
    // busy_o stays high through the data_rdy_o cycle, so an edge seen there
    // is dropped rather than starting a burst that overlaps the output.
    assign start      = (state == IDLE) & sync_edge & ~busy_o;
    assign last_smp   = strobe & (smp_cnt == CNT_W'(N - 1));
    // A strobe in the expiry cycle takes precedence over the abort.
    assign expire     = (state == REQ) & ~strobe & (tmo_cnt == TMO_W'(TIMEOUT - 1));
    assign sample_ext = ACC_W'(signed'(adc_data_i));

    // Request is a pure decode of the state register, hence glitch-free.
    assign adc_data_req_o = (state == REQ);

`ifdef ADC_AVG_ROUND_EN
    // Half an LSB of the result; zero when LOG2_N = 0 so the sample passes through.
    localparam logic [ACC_W-1:0] RND = ACC_W'((1 << LOG2_N) >> 1);
    assign acc_rnd = acc + RND;
`else
    assign acc_rnd = acc;
`endif

    // Two-flop synchronizer plus one extra stage for rising-edge detection; ready line delayed once.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q <= '0;
            rdy_z  <= 1'b0;
        end else begin
            sync_q <= {sync_q[1:0], syncro_i};
            rdy_z  <= adc_data_rdy_i;
        end
    end

    // Next-state decode for the burst sequencer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = (SYNC_DELAY == 0) ? REQ : DELAY;
            DELAY: if (dly_cnt == DLY_W'(SYNC_DELAY - 1)) next_state = REQ;
            REQ: begin
                if (last_smp)    next_state = OUT;
                else if (expire) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) state <= IDLE;
        else            state <= next_state;
    end

    // Burst datapath: delay, timeout and sample counters plus the accumulator.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            dly_cnt <= '0;
            tmo_cnt <= '0;
            smp_cnt <= '0;
            acc     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dly_cnt <= '0;
                    tmo_cnt <= '0;
                    smp_cnt <= '0;
                    acc     <= '0;
                end
                DELAY: dly_cnt <= dly_cnt + 1'b1;
                REQ: begin
                    if (strobe) begin
                        acc     <= acc + sample_ext;
                        smp_cnt <= smp_cnt + 1'b1;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs; busy covers the whole burst including the data_rdy_o cycle.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_o     <= '0;
            data_rdy_o <= 1'b0;
            busy_o     <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            data_rdy_o <= (state == OUT);
            timeout_o  <= expire;
            busy_o     <= (next_state != IDLE) | (state == OUT);
            if (state == OUT) data_o <= DATA_W'(acc_rnd >>> LOG2_N);
        end
    end

endmodule

// File: doc/adc_burst_avg.md
# adc_burst_avg

Parametrised burst-sampling averager between the external ADC handshake and downstream consumers. A pulse on `syncro_i` starts a burst: after a programmable delay the block requests samples, captures exactly 2^LOG2_N of them on falling edges of the ADC ready line, and emits their signed arithmetic mean with a one-cycle ready pulse. It adds configurable width, depth and delay, a stall timeout, a busy indication and optional rounding to the fixed 12-bit, 8-sample averager this block supersedes.

## Interface
- `DATA_W`, 12: sample/result width, signed two's complement, 4..16.
- `LOG2_N`, 3: log2 of samples per burst, 0..6 (N = 2^LOG2_N).
- `SYNC_DELAY`, 10: cycles between the sync edge being detected and `adc_data_req_o` rising, 0..255.
- `TIMEOUT`, 64: maximum cycles in REQ without a strobe before the burst aborts, 1..65535.
- `clk_i` in 1: the single clock; all logic is on its rising edge.
- `reset_n_i` in 1: asynchronous, active-low reset.
- `syncro_i` in 1: burst trigger; asynchronous to `clk_i`.
- `adc_data_req_o` out 1: sample request to the ADC.
- `adc_data_rdy_i` in 1: ADC ready; a falling edge marks a valid sample.
- `adc_data_i` in DATA_W: ADC sample, signed.
- `data_o` out DATA_W: averaged result, signed; holds its value between bursts.
- `data_rdy_o` out 1: one-cycle pulse when `data_o` updates.
- `busy_o` out 1: high from sync edge detection until return to IDLE.
- `timeout_o` out 1: one-cycle pulse on burst abort.

## Operation
- Input conditioning: `syncro_i` goes through a 2-flop synchronizer and a rising-edge detector (sync_edge). `adc_data_rdy_i` is registered once (rdy_z). strobe = rdy_z & !adc_data_rdy_i. The sample taken is `adc_data_i` in the strobe cycle.
- FSM states: IDLE, DELAY, REQ, OUT.
  - IDLE: sync_edge -> DELAY (or -> REQ when SYNC_DELAY = 0). Clear the accumulator, sample count and timeout counter.
  - DELAY: count SYNC_DELAY cycles, then -> REQ.
  - REQ: `adc_data_req_o` = 1.
    - Each strobe adds the sign-extended sample to the accumulator, increments the count and clears the timeout counter.
    - The N-th strobe -> OUT.
    - TIMEOUT consecutive cycles with no strobe -> IDLE with a `timeout_o` pulse; `data_o` is not updated and `data_rdy_o` stays low.
  - OUT: `data_o` <= result, `data_rdy_o` pulse, -> IDLE.
- Accumulator: signed, DATA_W+LOG2_N bits. Overflow is impossible by construction.
- Result = acc >>> LOG2_N (arithmetic shift), truncated to DATA_W. Rounding is controlled by the Configuration macro. LOG2_N = 0 passes the sample through unchanged.
- Ignored inputs:
  - sync_edge while `busy_o` = 1 (no restart, no queueing).
  - Strobes outside REQ.
- `adc_data_req_o` is registered and driven solely from the state register.
- Reset, at any time including mid-burst: immediate return to IDLE with all outputs low, `data_o` = 0, and synchronizer and accumulator cleared. No partial result is emitted.

## Timing
- Reset values: `adc_data_req_o`=0, `data_o`=0, `data_rdy_o`=0, `busy_o`=0, `timeout_o`=0.
- Sync latency:
  - A `syncro_i` high held for at least 2 clocks is detected within 3 edges.
  - `busy_o` rises on the edge after detection.
  - `adc_data_req_o` rises SYNC_DELAY cycles after `busy_o`.
- Last strobe in cycle c: the accumulator update is registered at the end of c, the FSM is in OUT during c+1, and `data_o`/`data_rdy_o` are valid in cycle c+2. `data_rdy_o` is high for exactly one cycle.
- `adc_data_req_o` falls at the end of cycle c, i.e. it is low from c+1.
- `busy_o` falls with `data_rdy_o`: low from c+3. A new sync edge may be accepted in c+3.
- Timeout: `timeout_o` is high for the one cycle after the TIMEOUT-th idle REQ cycle, coincident with `adc_data_req_o` = 0 and `busy_o` = 0.
- Strobe and timeout expiry in the same cycle: the strobe wins.

## Configuration
- `ADC_AVG_ROUND_EN`:
  - Defined: add 2^(LOG2_N-1) to the accumulator before the shift (round half up); no effect when LOG2_N = 0.
  - Undefined: pure arithmetic shift (floor).

## Test plan
Defaults: DATA_W=12, LOG2_N=3, SYNC_DELAY=10, TIMEOUT=64.
- Reset released with all inputs low -> all outputs 0 and no activity for 100 cycles.
- Sync pulse, then 8 strobes with samples 100..107 (sum 828):
  - `data_o`=104 with ROUND_EN, 103 without.
  - `data_rdy_o` high exactly one cycle, 2 cycles after the last strobe.
  - Request rises 10 cycles after `busy_o`.
- Samples: 4x 0xFFF (-1) and 4x 0xFFE (-2), sum -12:
  - `data_o` = 0xFFF with ROUND_EN, 0xFFE without.
  - All 8 samples 0x800 -> `data_o` = 0x800.
- 3 strobes, then none for 64 cycles:
  - `timeout_o` pulse, request and `busy_o` low, no `data_rdy_o`.
  - `data_o` keeps its previous value.
  - The next burst of 8x 50 -> 50.
- Second sync pulse mid-burst:
  - It is ignored; exactly one `data_rdy_o`.
  - Strobes while idle do not change the next result.
- `reset_n_i` low after 5 strobes -> outputs 0 immediately; after release, a fresh burst of 8x 7 -> `data_o`=7.
